// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator: branch-type encodings and
// a ceiling-log2 helper used to size slot indices, pointers and counters.
package fetch_pkg;

  localparam logic [1:0] BR_RETURN = 2'b00;
  localparam logic [1:0] BR_CALL   = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;
  localparam logic [1:0] BR_COND   = 2'b11;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fetch_target_queue.sv
// Generic FIFO used as the Fetch Target Queue.
// Flush empties the queue in one cycle and overrides a simultaneous dequeue.
// Optional macro FETCH_FTQ_BYPASS_EN: when the queue is empty, an incoming
// entry is shown on the read side in the same cycle and, if taken, is never
// written into storage.
module fetch_target_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  parameter int  PTR_W = clog2(DEPTH),
  parameter int  CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enqValid,
  input  T                 enqData,
  input  logic             deqReady,
  output logic             deqValid,
  output T                 deqData,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             full;
  logic             empty;
  logic             wrEn;
  logic             rdEn;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdEn  = ~empty & deqReady & ~flush;

`ifdef FETCH_FTQ_BYPASS_EN
  logic bypass;
  assign bypass   = empty & enqValid & ~flush;
  assign deqValid = ~empty | bypass;
  assign deqData  = empty ? enqData : mem[rdPtr];
  assign wrEn     = enqValid & ~full & ~flush & ~(bypass & deqReady);
`else
  assign deqValid = ~empty;
  assign deqData  = mem[rdPtr];
  assign wrEn     = enqValid & ~full & ~flush;
`endif

  // Entry storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= enqData;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-PC generator for a FETCH_WIDTH-wide fetch stage.
// Picks the next PC from redirects, the first effective BTB hit or the
// sequential block address, drives RAS push/pop and enqueues one block
// descriptor per advance into the Fetch Target Queue.
// Optional macro FETCH_FTQ_BYPASS_EN enables same-cycle FTQ bypass when empty.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int INST_BYTES  = 8,
  parameter int PC_W        = 32,
  parameter int FTQ_DEPTH   = 4,
  parameter int SLOT_W      = (FETCH_WIDTH > 1) ? clog2(FETCH_WIDTH) : 1,
  parameter int CNT_W       = clog2(FTQ_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        recoverEX_i,
  input  logic [PC_W-1:0]             targetEX_i,
  input  logic                        recoverID_i,
  input  logic                        rtrID_i,
  input  logic [PC_W-1:0]             targetID_i,
  input  logic [PC_W-1:0]             rasTop_i,
  input  logic [PC_W-1:0]             rasTopCP_i,
  input  logic [FETCH_WIDTH-1:0]      btbHit_i,
  input  logic [2*FETCH_WIDTH-1:0]    btbType_i,
  input  logic [FETCH_WIDTH-1:0]      pred_i,
  input  logic [PC_W*FETCH_WIDTH-1:0] btbTarget_i,
  output logic [PC_W-1:0]             pc_o,
  output logic                        rasPush_o,
  output logic [PC_W-1:0]             rasPushAddr_o,
  output logic                        rasPop_o,
  output logic                        ftqValid_o,
  input  logic                        ftqReady_i,
  output logic [PC_W-1:0]             ftqPc_o,
  output logic                        ftqTaken_o,
  output logic [SLOT_W-1:0]           ftqSlot_o,
  output logic [PC_W-1:0]             ftqNextPc_o,
  output logic [CNT_W-1:0]            ftqCount_o
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [SLOT_W-1:0] slot;
    logic [PC_W-1:0]   nextPc;
  } ftqEntry_t;

  logic [PC_W-1:0]        pcReg;
  logic [FETCH_WIDTH-1:0] eff;
  logic                   hitAny;
  logic [SLOT_W-1:0]      k;
  logic [1:0]             typeK;
  logic [PC_W-1:0]        targetK;
  logic [PC_W-1:0]        seqPc;
  logic [PC_W-1:0]        predNext;
  logic                   recovery;
  logic [PC_W-1:0]        recTarget;
  logic                   advance;
  logic                   doPush;
  ftqEntry_t              enqEntry;
  ftqEntry_t              headEntry;

  // Effective hits: conditional branches count only when predicted taken.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      eff[i] = btbHit_i[i] & (pred_i[i] | (btbType_i[2*i +: 2] != BR_COND));
    end
  end

  // Priority encoder: lowest effective slot wins, scanning high to low.
  always_comb begin
    k = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (eff[i]) k = SLOT_W'(i);
    end
  end

  assign hitAny  = |eff;
  assign typeK   = btbType_i[2*k +: 2];
  assign targetK = btbTarget_i[PC_W*k +: PC_W];
  assign seqPc   = pcReg + PC_W'(FETCH_WIDTH * INST_BYTES);

  // Predicted successor: returns use the RAS top, other hits the BTB target.
  always_comb begin
    predNext = seqPc;
    if (hitAny) predNext = (typeK == BR_RETURN) ? rasTop_i : targetK;
  end

  // Redirect selection: execute stage outranks decode stage.
  always_comb begin
    recTarget = targetID_i;
    if (recoverEX_i)  recTarget = targetEX_i;
    else if (rtrID_i) recTarget = rasTopCP_i;
  end

  assign recovery = recoverEX_i | recoverID_i;
  assign advance  = ~reset & ~recovery & ~stall_i & (ftqCount_o < CNT_W'(FTQ_DEPTH));

  // PC register: redirects always win; otherwise step only on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pcReg <= '0;
    else if (recovery) pcReg <= recTarget;
    else if (advance)  pcReg <= predNext;
  end

  assign pc_o          = pcReg;
  assign doPush        = advance & hitAny & (typeK == BR_CALL);
  assign rasPush_o     = doPush;
  assign rasPop_o      = advance & hitAny & (typeK == BR_RETURN);
  assign rasPushAddr_o = doPush ? pcReg + PC_W'((32'(k) + 32'd1) * 32'(INST_BYTES)) : pcReg;

  assign enqEntry.pc     = pcReg;
  assign enqEntry.taken  = hitAny;
  assign enqEntry.slot   = k;
  assign enqEntry.nextPc = predNext;

  fetch_target_queue #(
    .DEPTH (FTQ_DEPTH),
    .T     (ftqEntry_t),
    .CNT_W (CNT_W)
  ) uFtq (
    .clk      (clk),
    .reset    (reset),
    .flush    (recovery),
    .enqValid (advance),
    .enqData  (enqEntry),
    .deqReady (ftqReady_i),
    .deqValid (ftqValid_o),
    .deqData  (headEntry),
    .count    (ftqCount_o)
  );

  assign ftqPc_o     = headEntry.pc;
  assign ftqTaken_o  = headEntry.taken;
  assign ftqSlot_o   = headEntry.slot;
  assign ftqNextPc_o = headEntry.nextPc;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with default parameters
// (FETCH_WIDTH=4, INST_BYTES=8, PC_W=32, FTQ_DEPTH=4, no FTQ bypass).
module tb_fetch_pc_gen;

  logic          clk;
  logic          reset;
  logic          stall_i;
  logic          recoverEX_i;
  logic [31:0]   targetEX_i;
  logic          recoverID_i;
  logic          rtrID_i;
  logic [31:0]   targetID_i;
  logic [31:0]   rasTop_i;
  logic [31:0]   rasTopCP_i;
  logic [3:0]    btbHit_i;
  logic [7:0]    btbType_i;
  logic [3:0]    pred_i;
  logic [127:0]  btbTarget_i;
  logic [31:0]   pc_o;
  logic          rasPush_o;
  logic [31:0]   rasPushAddr_o;
  logic          rasPop_o;
  logic          ftqValid_o;
  logic          ftqReady_i;
  logic [31:0]   ftqPc_o;
  logic          ftqTaken_o;
  logic [1:0]    ftqSlot_o;
  logic [31:0]   ftqNextPc_o;
  logic [2:0]    ftqCount_o;

  int compared   = 0;
  int mismatched = 0;

  fetch_pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .recoverEX_i   (recoverEX_i),
    .targetEX_i    (targetEX_i),
    .recoverID_i   (recoverID_i),
    .rtrID_i       (rtrID_i),
    .targetID_i    (targetID_i),
    .rasTop_i      (rasTop_i),
    .rasTopCP_i    (rasTopCP_i),
    .btbHit_i      (btbHit_i),
    .btbType_i     (btbType_i),
    .pred_i        (pred_i),
    .btbTarget_i   (btbTarget_i),
    .pc_o          (pc_o),
    .rasPush_o     (rasPush_o),
    .rasPushAddr_o (rasPushAddr_o),
    .rasPop_o      (rasPop_o),
    .ftqValid_o    (ftqValid_o),
    .ftqReady_i    (ftqReady_i),
    .ftqPc_o       (ftqPc_o),
    .ftqTaken_o    (ftqTaken_o),
    .ftqSlot_o     (ftqSlot_o),
    .ftqNextPc_o   (ftqNextPc_o),
    .ftqCount_o    (ftqCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearHits();
    btbHit_i    = '0;
    btbType_i   = '0;
    pred_i      = '0;
    btbTarget_i = '0;
  endtask

  task automatic redirectEX(input logic [31:0] tgt);
    recoverEX_i = 1'b1;
    targetEX_i  = tgt;
    step();
    recoverEX_i = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    stall_i     = 1'b0;
    recoverEX_i = 1'b0;
    targetEX_i  = '0;
    recoverID_i = 1'b0;
    rtrID_i     = 1'b0;
    targetID_i  = '0;
    rasTop_i    = '0;
    rasTopCP_i  = '0;
    ftqReady_i  = 1'b1;
    clearHits();
    #3;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'b0, ftqValid_o}, 32'h0);
    check("rst_count", {29'b0, ftqCount_o}, 32'h0);
    check("rst_push", {31'b0, rasPush_o}, 32'h0);
    check("rst_pop", {31'b0, rasPop_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Sequential fetch
    check("seq_pc0", pc_o, 32'h0);
    step();
    check("seq_pc1", pc_o, 32'h20);
    check("seq_head0_pc", ftqPc_o, 32'h0);
    check("seq_head0_next", ftqNextPc_o, 32'h20);
    check("seq_head0_taken", {31'b0, ftqTaken_o}, 32'h0);
    step();
    check("seq_pc2", pc_o, 32'h40);
    check("seq_head1_pc", ftqPc_o, 32'h20);
    check("seq_head1_next", ftqNextPc_o, 32'h40);
    check("seq_count", {29'b0, ftqCount_o}, 32'h1);

    // Conditional: slot0 not predicted, slot1 predicted taken
    redirectEX(32'h100);
    check("cond_pc_redir", pc_o, 32'h100);
    check("cond_count_flush", {29'b0, ftqCount_o}, 32'h0);
    btbHit_i            = 4'b0011;
    btbType_i           = 8'b0000_1111;
    pred_i              = 4'b0010;
    btbTarget_i[31:0]   = 32'h300;
    btbTarget_i[63:32]  = 32'h400;
    #1;
    check("cond_push", {31'b0, rasPush_o}, 32'h0);
    check("cond_pop", {31'b0, rasPop_o}, 32'h0);
    step();
    clearHits();
    #1;
    check("cond_pc", pc_o, 32'h400);
    check("cond_head_pc", ftqPc_o, 32'h100);
    check("cond_head_taken", {31'b0, ftqTaken_o}, 32'h1);
    check("cond_head_slot", {30'b0, ftqSlot_o}, 32'h1);
    check("cond_head_next", ftqNextPc_o, 32'h400);

    // Call in slot2, then return in slot0
    redirectEX(32'h200);
    btbHit_i            = 4'b0100;
    btbType_i           = 8'b0001_0000;
    btbTarget_i[95:64]  = 32'h800;
    #1;
    check("call_push", {31'b0, rasPush_o}, 32'h1);
    check("call_push_addr", rasPushAddr_o, 32'h218);
    check("call_pop", {31'b0, rasPop_o}, 32'h0);
    step();
    clearHits();
    #1;
    check("call_pc", pc_o, 32'h800);
    check("call_head_slot", {30'b0, ftqSlot_o}, 32'h2);
    btbHit_i  = 4'b0001;
    btbType_i = 8'b0000_0000;
    rasTop_i  = 32'h1234;
    #1;
    check("ret_pop", {31'b0, rasPop_o}, 32'h1);
    check("ret_push", {31'b0, rasPush_o}, 32'h0);
    check("ret_push_addr_idle", rasPushAddr_o, 32'h800);
    step();
    clearHits();
    #1;
    check("ret_pc", pc_o, 32'h1234);
    check("ret_head_pc", ftqPc_o, 32'h800);
    check("ret_head_next", ftqNextPc_o, 32'h1234);
    check("ret_count", {29'b0, ftqCount_o}, 32'h1);

    // Back-pressure: FTQ fills and PC holds, then drains in order
    redirectEX(32'h1000);
    ftqReady_i = 1'b0;
    repeat (6) step();
    check("full_count", {29'b0, ftqCount_o}, 32'h4);
    check("full_pc_hold", pc_o, 32'h1080);
    check("full_head", ftqPc_o, 32'h1000);
    ftqReady_i = 1'b1;
    #1;
    check("full_push_idle", {31'b0, rasPush_o}, 32'h0);
    step();
    check("drain0_head", ftqPc_o, 32'h1020);
    check("drain0_pc", pc_o, 32'h1080);
    check("drain0_count", {29'b0, ftqCount_o}, 32'h3);
    step();
    check("drain1_head", ftqPc_o, 32'h1040);
    check("drain1_pc", pc_o, 32'h10A0);
    step();
    check("drain2_head", ftqPc_o, 32'h1060);
    check("drain2_pc", pc_o, 32'h10C0);
    check("drain2_count", {29'b0, ftqCount_o}, 32'h3);

    // Simultaneous EX and ID recovery with a call hit present
    recoverEX_i = 1'b1;
    targetEX_i  = 32'h900;
    recoverID_i = 1'b1;
    targetID_i  = 32'hA00;
    btbHit_i    = 4'b0001;
    btbType_i   = 8'b0000_0001;
    #1;
    check("rec_push", {31'b0, rasPush_o}, 32'h0);
    check("rec_pop", {31'b0, rasPop_o}, 32'h0);
    step();
    recoverEX_i = 1'b0;
    recoverID_i = 1'b0;
    clearHits();
    #1;
    check("rec_pc", pc_o, 32'h900);
    check("rec_count", {29'b0, ftqCount_o}, 32'h0);
    check("rec_valid", {31'b0, ftqValid_o}, 32'h0);
    step();
    check("rec_enq_head", ftqPc_o, 32'h900);
    check("rec_enq_count", {29'b0, ftqCount_o}, 32'h1);

    // Decode-stage redirects: return uses checkpoint top, else target
    recoverID_i = 1'b1;
    rtrID_i     = 1'b1;
    rasTopCP_i  = 32'h5550;
    targetID_i  = 32'h6660;
    step();
    check("id_rtr_pc", pc_o, 32'h5550);
    rtrID_i = 1'b0;
    step();
    recoverID_i = 1'b0;
    check("id_tgt_pc", pc_o, 32'h6660);

    // Stall holds the PC
    stall_i = 1'b1;
    step();
    step();
    check("stall_pc", pc_o, 32'h6660);
    stall_i = 1'b0;

    // Sequential wrap modulo 2^32
    redirectEX(32'hFFFF_FFF0);
    step();
    check("wrap_pc", pc_o, 32'h10);

    // Async reset mid-cycle with two entries queued
    redirectEX(32'h2000);
    ftqReady_i = 1'b0;
    step();
    step();
    check("pre_rst_count", {29'b0, ftqCount_o}, 32'h2);
    btbHit_i  = 4'b0001;
    btbType_i = 8'b0000_0001;
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", {31'b0, ftqValid_o}, 32'h0);
    check("arst_count", {29'b0, ftqCount_o}, 32'h0);
    check("arst_push", {31'b0, rasPush_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
